out_dma: RTL and testbench
==========================

Name: out_dma

Overview:
- AXI4 write-master DMA that drains results from the on-chip output buffer to DRAM.
- Write-direction counterpart of the activation read DMA: same CSR-style start/done/busy/error control, same bridge-facing AXI ID scheme.
- Reads 64-bit words from the output buffer (1-cycle read latency) and emits INCR bursts of at most 16 beats, never crossing a 4KB boundary.

Parameters:
AXI_ADDR_W, 32, address width
AXI_DATA_W, 64, data width (fixed 8 bytes/beat)
AXI_ID_W, 4, AXI ID width
STREAM_ID, 2, constant driven on m_axi_awid
BURST_LEN, 8'd15, max awlen (16 beats)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle start pulse, ignored while busy
dst_addr  in  AXI_ADDR_W  DRAM byte address, 8-byte aligned
transfer_length  in  32  bytes to write
done  out  1  one-cycle completion pulse
busy  out  1  high from accepted start until done
error  out  1  sticky until next accepted start; set on non-OKAY bresp
m_axi_awid  out  AXI_ID_W  constant STREAM_ID
m_axi_awaddr  out  AXI_ADDR_W  burst address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  constant 3'b011
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1  AW valid
m_axi_awready  in  1  AW ready
m_axi_wdata  out  AXI_DATA_W  write data
m_axi_wstrb  out  8  byte strobes
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid  out  1  W valid
m_axi_wready  in  1  W ready
m_axi_bid  in  AXI_ID_W  ignored (bridge routes by ID)
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  B valid
m_axi_bready  out  1  B ready
buf_re  out  1  output-buffer read enable
buf_raddr  out  AXI_ADDR_W  word index, 0..beats-1
buf_rdata  in  AXI_DATA_W  valid the cycle after buf_re

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE; done, busy, error, awvalid, wvalid, wlast, bready, buf_re = 0; buf_raddr=0; skid FIFO emptied.
  - Reset mid-transfer abandons the transfer with no further AXI activity.
- Accepted start (IDLE only):
  - Latch addr=dst_addr; total_beats=ceil(transfer_length/8); tail_bytes=transfer_length%8; clear error; busy=1.
  - transfer_length==0: no AXI traffic; done pulses the cycle after start; busy returns to 0 that same cycle.
- Burst sizing: beats = min(16, remaining_beats, (4096 - addr[11:0])/8); awlen = beats-1 (width 8, computed in 13 bits).
- States:
  - IDLE -> SEND_AW: on accepted start with non-zero length.
  - SEND_AW: awvalid held with stable fields until awready. Next state WRITE_DATA.
  - WRITE_DATA: stream beats; no W beat may precede acceptance of its AW. Next state WAIT_B after the wlast handshake.
  - WAIT_B: bready=1; one outstanding burst max. On bvalid:
    - bresp!=OKAY: error=1, go to DONE.
    - else if remaining_beats==0: go to DONE.
    - else addr += beats*8, go to SEND_AW.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Data path:
  - 2-entry skid FIFO between buffer and W channel.
  - buf_re issued when (occupancy + reads in flight) < 2 and beats remain to be read in the current burst.
  - buf_raddr increments per read and continues across bursts.
  - wvalid = FIFO non-empty. Full throughput (1 beat/cycle) when wready is held high.
  - Under wready backpressure: no data loss or duplication; wdata/wstrb/wlast stable while wvalid && !wready.
- wstrb: 8'hFF, except the final beat of the whole transfer when tail_bytes!=0, where it is (1<<tail_bytes)-1.
- Error ends the transfer only after the current burst's B response; no AW is issued after the error.
- Assertions (non-Verilator sim only): zero-length start (warn), misaligned dst_addr, awaddr+len crossing 4KB.

Decomposition:
- Shared package (existing DMA package, extended as needed): AXI_SIZE_64, AXI_BURST_INCR, RESP_OKAY constants; a wr_state_t enum (IDLE, SEND_AW, WRITE_DATA, WAIT_B, DONE_STATE).
- One sub-module, out_dma_skid: 2-entry valid/ready FIFO carrying {wdata, wstrb, wlast}.

Test Plan:
- dst 0x1000, len 64, all ready high -> one AW (awlen=7), 8 W beats on consecutive cycles, wlast on beat 8, wstrb 0xFF, buf_raddr 0..7, done pulse 1 cycle after B.
- dst 0x2000, len 204 -> AW awlen=15 @0x2000 then awlen=9 @0x2080; 26 beats; final wstrb 0x0F; done=1, error=0.
- dst 0x0FC0, len 128 -> awlen=7 @0x0FC0 then awlen=7 @0x1000; no 4KB-crossing assertion fires.
- len 128, wready toggling 1/0 and awready delayed 3 cycles -> W data equals buffer words 0..15 in order, no drops or duplicates; wvalid never before AW handshake.
- len 256, bresp=SLVERR on first B -> error=1, done pulse, no second AW; error clears on next start.
- rst_n low mid-WRITE_DATA, then start len 0 -> all outputs 0 after reset edge; done pulses the next cycle with no AW.

Source files
------------

// File: rtl/out_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : out_dma_pkg
//  Description : Shared definitions for the output-buffer write DMA:
//                AXI encoding constants, the write-side state type and the
//                burst-sizing / tail-strobe helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package out_dma_pkg;

  localparam logic [2:0] AXI_SIZE_64    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_AW    = 3'd1,
    WRITE_DATA = 3'd2,
    WAIT_B     = 3'd3,
    DONE_STATE = 3'd4
  } wr_state_t;

  // Beats in the next burst: the smallest of the burst cap, the beats still
  // owed, and the 8-byte beats left before the next 4KB page boundary.
  function automatic logic [12:0] burst_beats(
    input logic [11:0] addr_lo,
    input logic [31:0] remaining,
    input logic [12:0] max_beats
  );
    logic [12:0] room;
    logic [12:0] beats;
    room  = (13'd4096 - {1'b0, addr_lo}) >> 3;
    beats = max_beats;
    if (remaining < {19'd0, max_beats}) beats = remaining[12:0];
    if (room < beats) beats = room;
    return beats;
  endfunction

  // Byte strobes for the final beat of a transfer; tail==0 means a full beat.
  function automatic logic [7:0] tail_strb(input logic [2:0] tail);
    logic [8:0] mask;
    mask = (9'd1 << tail) - 9'd1;
    return (tail == 3'd0) ? 8'hFF : mask[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/out_dma_skid.sv
`default_nettype none
// ============================================================================
//  Module      : out_dma_skid
//  Description : Two-entry valid/ready FIFO between the output-buffer read
//                pipeline and the AXI W channel. The head entry is held
//                stable until it is popped.
//  Ports       : clk, rst_n       - clock, synchronous active-low reset
//                push_valid/data  - write side (caller guarantees space)
//                pop_valid/data   - head entry, pop_ready consumes it
//                count            - current occupancy (0..2)
//  Revision    : 1.0  initial release
// ============================================================================
module out_dma_skid #(
  parameter int unsigned WIDTH = 73
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign pop_valid = (count_q != 2'd0);
  assign pop_data  = mem_q[rd_ptr_q];
  assign pop       = pop_valid && pop_ready;
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push_valid} - {1'b0, pop};
    if (push_valid) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed when count_q says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(push_valid && count_q == 2'd2 && !pop_ready))
      else $error("out_dma_skid: push into full FIFO");
  end

endmodule
`default_nettype wire

// File: rtl/out_dma.sv
`default_nettype none
// ============================================================================
//  Module      : out_dma
//  Description : AXI4 write-master DMA draining the on-chip output buffer to
//                DRAM in INCR bursts of up to BURST_LEN+1 beats that never
//                cross a 4KB page. One burst outstanding at a time.
//  Ports       : clk, rst_n                    - clock, sync active-low reset
//                start/dst_addr/transfer_length - job request (IDLE only)
//                done/busy/error               - job status
//                m_axi_aw*/w*/b*               - AXI4 write channels
//                buf_re/buf_raddr/buf_rdata    - output buffer, 1-cycle read
//  Revision    : 1.0  initial release
// ============================================================================
module out_dma
  import out_dma_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 64,
  parameter int unsigned AXI_ID_W   = 4,
  parameter int unsigned STREAM_ID  = 2,
  parameter logic [7:0]  BURST_LEN  = 8'd15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AXI_ADDR_W-1:0] dst_addr,
  input  logic [31:0]           transfer_length,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic [AXI_ID_W-1:0]   m_axi_awid,
  output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [AXI_DATA_W-1:0] m_axi_wdata,
  output logic [7:0]            m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [AXI_ID_W-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  buf_re,
  output logic [AXI_ADDR_W-1:0] buf_raddr,
  input  logic [AXI_DATA_W-1:0] buf_rdata
);

  localparam int unsigned FIFO_W    = AXI_DATA_W + 8 + 1;
  localparam logic [12:0] MAX_BEATS = {5'd0, BURST_LEN} + 13'd1;

  wr_state_t             state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [AXI_ADDR_W-1:0] raddr_q, raddr_d;
  logic [31:0]           rem_q, rem_d;        // beats not yet assigned to a burst
  logic [2:0]            tail_q, tail_d;
  logic                  error_q, error_d;
  logic [4:0]            burst_q, burst_d;    // beats in the burst in flight
  logic [4:0]            rd_left_q, rd_left_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_last_q, rd_last_d;
  logic                  rd_final_q, rd_final_d;

  logic [12:0]           beats;
  logic [12:0]           awlen_full;
  logic [31:0]           total_beats;
  logic                  aw_hs, w_hs, rd_ok, rd_last;
  logic [2:0]            pending;
  logic                  fifo_valid, fifo_ready;
  logic [FIFO_W-1:0]     fifo_in, fifo_out;
  logic [1:0]            fifo_count;
  logic                  unused_ok;

  assign beats       = burst_beats(addr_q[11:0], rem_q, MAX_BEATS);
  assign awlen_full  = beats - 13'd1;
  assign total_beats = 32'(({1'b0, transfer_length} + 33'd7) >> 3);
  assign unused_ok   = ^{m_axi_bid, awlen_full[12:8]};

  // AXI constant fields and channel handshakes
  assign m_axi_awid    = AXI_ID_W'(STREAM_ID);
  assign m_axi_awsize  = AXI_SIZE_64;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_full[7:0];
  assign m_axi_awvalid = (state_q == SEND_AW);
  assign m_axi_bready  = (state_q == WAIT_B);
  assign aw_hs         = m_axi_awvalid && m_axi_awready;

  // W is gated by state so no beat can precede its burst's AW handshake,
  // even though the FIFO may already hold data.
  assign m_axi_wvalid = fifo_valid && (state_q == WRITE_DATA);
  assign fifo_ready   = m_axi_wready && (state_q == WRITE_DATA);
  assign w_hs         = m_axi_wvalid && m_axi_wready;
  assign m_axi_wdata  = fifo_out[FIFO_W-1:9];
  assign m_axi_wstrb  = fifo_out[8:1];
  assign m_axi_wlast  = m_axi_wvalid && fifo_out[0];

  // Occupancy after this cycle's pop plus the read already in flight; using
  // the post-pop value keeps one read per cycle when wready stays high.
  assign pending = {1'b0, fifo_count} - {2'b0, w_hs} + {2'b0, rd_vld_q};
  assign rd_ok   = (pending < 3'd2);
  assign buf_re  = (state_q == WRITE_DATA) && (rd_left_q != 5'd0) && rd_ok;
  assign buf_raddr = raddr_q;
  assign rd_last   = (rd_left_q == 5'd1);

  assign fifo_in = {buf_rdata, (rd_final_q ? tail_strb(tail_q) : 8'hFF), rd_last_q};

  assign done  = (state_q == DONE_STATE);
  assign busy  = (state_q == SEND_AW) || (state_q == WRITE_DATA) || (state_q == WAIT_B);
  assign error = error_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    raddr_d    = raddr_q;
    rem_d      = rem_q;
    tail_d     = tail_q;
    error_d    = error_q;
    burst_d    = burst_q;
    rd_left_d  = rd_left_q;
    rd_vld_d   = buf_re;
    rd_last_d  = rd_last;
    // rem_q already excludes the current burst, so zero marks the final beat
    rd_final_d = rd_last && (rem_q == 32'd0);

    if (buf_re) begin
      rd_left_d = rd_left_q - 5'd1;
      raddr_d   = raddr_q + AXI_ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = dst_addr;
          rem_d   = total_beats;
          tail_d  = transfer_length[2:0];
          error_d = 1'b0;
          raddr_d = '0;
          state_d = (transfer_length == 32'd0) ? DONE_STATE : SEND_AW;
        end
      end
      SEND_AW: begin
        if (aw_hs) begin
          burst_d   = beats[4:0];
          rd_left_d = beats[4:0];
          rem_d     = rem_q - 32'(beats);
          state_d   = WRITE_DATA;
        end
      end
      WRITE_DATA: begin
        if (w_hs && m_axi_wlast) state_d = WAIT_B;
      end
      WAIT_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY) begin
            error_d = 1'b1;
            state_d = DONE_STATE;
          end else if (rem_q == 32'd0) begin
            state_d = DONE_STATE;
          end else begin
            addr_d  = addr_q + (AXI_ADDR_W'(burst_q) << 3);
            state_d = SEND_AW;
          end
        end
      end
      DONE_STATE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      raddr_q    <= '0;
      rem_q      <= 32'd0;
      tail_q     <= 3'd0;
      error_q    <= 1'b0;
      burst_q    <= 5'd0;
      rd_left_q  <= 5'd0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_final_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      raddr_q    <= raddr_d;
      rem_q      <= rem_d;
      tail_q     <= tail_d;
      error_q    <= error_d;
      burst_q    <= burst_d;
      rd_left_q  <= rd_left_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      rd_final_q <= rd_final_d;
    end
  end

  out_dma_skid #(.WIDTH(FIFO_W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (rd_vld_q),
    .push_data  (fifo_in),
    .pop_valid  (fifo_valid),
    .pop_data   (fifo_out),
    .pop_ready  (fifo_ready),
    .count      (fifo_count)
  );

  always @(posedge clk) begin
    if (rst_n && start && state_q == IDLE) begin
      if (transfer_length == 32'd0) $warning("out_dma: zero-length start");
      assert (dst_addr[2:0] == 3'd0) else $error("out_dma: misaligned dst_addr");
    end
    if (rst_n && m_axi_awvalid)
      assert (({1'b0, m_axi_awaddr[11:0]} + ((13'(m_axi_awlen) + 13'd1) << 3)) <= 13'd4096)
        else $error("out_dma: burst crosses 4KB boundary");
  end

endmodule
`default_nettype wire

// File: tb/tb_out_dma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_dma
//  Description : Self-checking bench for out_dma. A buffer model serves
//                deterministic words; an AXI slave model with configurable
//                AW delay / W backpressure / error response checks each AW,
//                W and B handshake against scoreboard queues filled when a
//                transfer is launched.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_out_dma;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_exp_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dst_addr;
  logic [31:0] transfer_length;
  logic        done, busy, error;
  logic [3:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        buf_re;
  logic [31:0] buf_raddr;
  logic [63:0] buf_rdata;

  aw_exp_t exp_aw[$];
  w_exp_t  exp_w[$];
  bit      exp_b[$];

  int n_checks = 0;
  int n_pass   = 0;

  // slave / monitor control and state
  int  tnum = 0;
  int  aw_delay = 0;
  bit  w_toggle = 0;
  bit  err_inject = 0;
  int  aw_wait, aw_hs, wl_cnt, b_pend, w_cnt, cyc;
  int  w_first_cyc, w_last_cyc;
  bit  b_fire, b_final, w_stall, aw_stall;
  logic [63:0] p_wdata;
  logic [7:0]  p_wstrb;
  logic        p_wlast;
  logic [31:0] p_awaddr;
  logic [7:0]  p_awlen;

  out_dma dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .dst_addr        (dst_addr),
    .transfer_length (transfer_length),
    .done            (done),
    .busy            (busy),
    .error           (error),
    .m_axi_awid      (m_axi_awid),
    .m_axi_awaddr    (m_axi_awaddr),
    .m_axi_awlen     (m_axi_awlen),
    .m_axi_awsize    (m_axi_awsize),
    .m_axi_awburst   (m_axi_awburst),
    .m_axi_awvalid   (m_axi_awvalid),
    .m_axi_awready   (m_axi_awready),
    .m_axi_wdata     (m_axi_wdata),
    .m_axi_wstrb     (m_axi_wstrb),
    .m_axi_wlast     (m_axi_wlast),
    .m_axi_wvalid    (m_axi_wvalid),
    .m_axi_wready    (m_axi_wready),
    .m_axi_bid       (m_axi_bid),
    .m_axi_bresp     (m_axi_bresp),
    .m_axi_bvalid    (m_axi_bvalid),
    .m_axi_bready    (m_axi_bready),
    .buf_re          (buf_re),
    .buf_raddr       (buf_raddr),
    .buf_rdata       (buf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] word(input int t, input logic [31:0] k);
    return {t[7:0], k[23:0], k ^ 32'h9E37_79B9};
  endfunction

  // Output buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (buf_re) buf_rdata <= word(tnum, buf_raddr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected AW/W/B sequence for one transfer; with err only the first burst.
  task automatic plan(input logic [31:0] dst, input int len, input bit err);
    int n, rem, k, room, b;
    logic [31:0] a;
    logic [7:0]  s;
    n = (len + 7) / 8;
    rem = n;
    a = dst;
    k = 0;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 8;
      b = 16;
      if (rem < b) b = rem;
      if (room < b) b = room;
      exp_aw.push_back('{addr: a, len: 8'(b - 1)});
      for (int j = 0; j < b; j++) begin
        s = 8'hFF;
        if (k == n - 1 && (len % 8) != 0) s = 8'((1 << (len % 8)) - 1);
        exp_w.push_back('{data: word(tnum, 32'(k)), strb: s, last: (j == b - 1)});
        k++;
      end
      rem -= b;
      a += 32'(b * 8);
      exp_b.push_back((rem == 0) || err);
      if (err) break;
    end
  endtask

  // AXI slave and channel monitor, acting on the falling edge.
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
    m_axi_bresp = 2'b00; m_axi_bid = 4'd2;
    cyc = 0; w_cnt = 0; w_first_cyc = 0; w_last_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
        aw_wait = 0; aw_hs = 0; wl_cnt = 0; b_pend = 0;
        b_fire = 0; b_final = 0; w_stall = 0; aw_stall = 0;
      end else begin
        // B channel
        if (b_fire) begin
          chk("done_after_b", done, b_final);
          m_axi_bvalid = 0;
          b_fire = 0;
        end
        if (!m_axi_bvalid && b_pend > 0) begin
          m_axi_bvalid = 1;
          m_axi_bresp  = err_inject ? 2'b10 : 2'b00;
          err_inject   = 0;
          b_pend--;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          b_fire = 1;
          chk("b_expected", 64'(exp_b.size() > 0), 1);
          if (exp_b.size() > 0) b_final = exp_b.pop_front();
        end

        // W channel
        m_axi_wready = w_toggle ? ~m_axi_wready : 1'b1;
        if (w_stall) begin
          chk("w_hold_valid", m_axi_wvalid, 1);
          chk("w_hold_data", m_axi_wdata, p_wdata);
          chk("w_hold_strb", m_axi_wstrb, p_wstrb);
          chk("w_hold_last", m_axi_wlast, p_wlast);
        end
        if (m_axi_wvalid) begin
          chk("w_after_aw", 64'(aw_hs > wl_cnt), 1);
          if (m_axi_wready) begin
            chk("w_expected", 64'(exp_w.size() > 0), 1);
            if (exp_w.size() > 0) begin
              w_exp_t e;
              e = exp_w.pop_front();
              chk("wdata", m_axi_wdata, e.data);
              chk("wstrb", m_axi_wstrb, e.strb);
              chk("wlast", m_axi_wlast, e.last);
            end
            if (w_cnt == 0) w_first_cyc = cyc;
            w_last_cyc = cyc;
            w_cnt++;
            if (m_axi_wlast) begin
              wl_cnt++;
              b_pend++;
            end
          end
        end
        w_stall = m_axi_wvalid && !m_axi_wready;
        p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb; p_wlast = m_axi_wlast;

        // AW channel
        m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
        if (aw_stall) begin
          chk("aw_hold_valid", m_axi_awvalid, 1);
          chk("aw_hold_addr", m_axi_awaddr, p_awaddr);
          chk("aw_hold_len", m_axi_awlen, p_awlen);
        end
        if (m_axi_awvalid) begin
          aw_wait++;
          if (m_axi_awready) begin
            chk("aw_expected", 64'(exp_aw.size() > 0), 1);
            if (exp_aw.size() > 0) begin
              aw_exp_t e;
              e = exp_aw.pop_front();
              chk("awaddr", m_axi_awaddr, e.addr);
              chk("awlen", m_axi_awlen, e.len);
            end
            chk("aw_fixed", {m_axi_awid, m_axi_awsize, m_axi_awburst}, {4'd2, 3'b011, 2'b01});
            chk("aw_4k", 64'(((m_axi_awaddr % 4096) + (32'(m_axi_awlen) + 1) * 8) <= 4096), 1);
            aw_hs++;
            aw_wait = 0;
          end
        end
        aw_stall = m_axi_awvalid && !m_axi_awready;
        p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;
      end
    end
  end

  task automatic run_xfer(input logic [31:0] dst, input int len, input bit err,
                          input bit tog, input int awd, input int tn);
    int t;
    tnum = tn; w_toggle = tog; aw_delay = awd; err_inject = err;
    w_cnt = 0;
    plan(dst, len, err);
    start = 1; dst_addr = dst; transfer_length = 32'(len);
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, (len != 0));
    chk("error_cleared", error, 0);
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    chk("error_at_done", error, err);
    chk("aw_drained", exp_aw.size(), 0);
    chk("w_drained", exp_w.size(), 0);
    chk("b_drained", exp_b.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic chk_idle_outputs();
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_wlast", m_axi_wlast, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_buf_re", buf_re, 0);
    chk("rst_buf_raddr", buf_raddr, 0);
  endtask

  initial begin
    int t;
    rst_n = 0; start = 0; dst_addr = 0; transfer_length = 0;
    repeat (3) @(negedge clk);
    chk_idle_outputs();
    rst_n = 1;
    @(negedge clk);

    // single 8-beat burst, full throughput
    run_xfer(32'h0000_1000, 64, 0, 0, 0, 1);
    chk("t1_beats", w_cnt, 8);
    chk("t1_consecutive", w_last_cyc - w_first_cyc, 7);

    // 16 + 10 beats with partial final strobe
    run_xfer(32'h0000_2000, 204, 0, 0, 0, 2);
    chk("t2_beats", w_cnt, 26);

    // split at the 4KB page
    run_xfer(32'h0000_0FC0, 128, 0, 0, 0, 3);

    // W backpressure and late AW ready
    run_xfer(32'h0000_3000, 128, 0, 1, 3, 4);
    chk("t4_beats", w_cnt, 16);

    // SLVERR on first B: stop after the first burst, error sticky
    run_xfer(32'h0000_4000, 256, 1, 0, 0, 5);
    repeat (5) @(negedge clk);
    chk("t5_error_sticky", error, 1);
    chk("t5_no_more_aw", m_axi_awvalid, 0);
    run_xfer(32'h0000_5000, 64, 0, 0, 0, 6);

    // reset in the middle of a burst, then a zero-length job
    tnum = 7; w_toggle = 0; aw_delay = 0; err_inject = 0; w_cnt = 0;
    plan(32'h0000_6000, 128, 0);
    start = 1; dst_addr = 32'h0000_6000; transfer_length = 128;
    @(negedge clk);
    start = 0;
    t = 0;
    while (w_cnt < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t6_mid_burst", 64'(w_cnt >= 3), 1);
    rst_n = 0;
    @(negedge clk);
    chk_idle_outputs();
    exp_aw.delete(); exp_w.delete(); exp_b.delete();
    rst_n = 1;
    @(negedge clk);
    run_xfer(32'h0000_7000, 0, 0, 0, 0, 8);
    chk("t6_no_aw", aw_hs, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
